// File: rtl/sram_controller.sv
// Turns one 32-bit MEM-stage read or write into two 16-bit accesses on an
// external single-port SRAM, holding each access for WAIT_CYCLES clocks.
module sram_controller #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_W_EN,
  input  logic        MEM_R_EN,
  input  logic [31:0] ALU_Res,
  input  logic [31:0] Val_Rm,
  output logic        ready,
  output logic [31:0] read_data,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          op_wr;
  logic [16:0]   word_idx;
  logic [31:0]   wdata;
  logic          req;
  logic [18:0]   offset;
  logic          unused_addr_bits;

  assign req = MEM_W_EN | MEM_R_EN;

  // Only bits [18:2] of (ALU_Res - ADDR_BASE) survive, so a 19-bit subtract is exact.
  assign offset           = ALU_Res[18:0] - 19'(ADDR_BASE);
  assign unused_addr_bits = ^{ALU_Res[31:19], offset[1:0]};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values and the simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      word_idx  <= '0;
      wdata     <= '0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr    <= MEM_W_EN;  // write wins when both enables are high
            word_idx <= offset[18:2];
            wdata    <= Val_Rm;
            cnt      <= CNT_LOAD;
            state    <= LO;
          end
        end
        LO: begin
          if (cnt == '0) begin
            if (!op_wr) read_data[15:0] <= sram_dq_in;
            cnt   <= CNT_LOAD;
            state <= HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HI: begin
          if (cnt == '0) begin
            if (!op_wr) read_data[31:16] <= sram_dq_in;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: ready = !req;
      LO, HI: begin
        sram_addr   = {word_idx, state == HI};
        sram_dq_oe  = op_wr;
        sram_we_n   = !op_wr;
        if (op_wr) sram_dq_out = (state == HI) ? wdata[31:16] : wdata[15:0];
      end
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller: a word-level memory model
// predicts read data; a monitor checks each completion and the SRAM bus.
module tb_sram_controller;

  localparam int BASE = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        w_en = 1'b0, r_en = 1'b0;
  logic [31:0] alu_res = '0, val_rm = '0;
  logic        ready;
  logic [31:0] read_data;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        w_en1 = 1'b0, r_en1 = 1'b0;
  logic [31:0] alu_res1 = '0, val_rm1 = '0;
  logic        ready1;
  logic [31:0] read_data1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;
  logic        sram_dq_oe1, sram_we_n1;

  sram_controller #(.WAIT_CYCLES(2), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .MEM_W_EN(w_en), .MEM_R_EN(r_en),
    .ALU_Res(alu_res), .Val_Rm(val_rm), .ready(ready), .read_data(read_data),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(1), .ADDR_BASE(BASE)) dut1 (
    .clk(clk), .rst(rst), .MEM_W_EN(w_en1), .MEM_R_EN(r_en1),
    .ALU_Res(alu_res1), .Val_Rm(val_rm1), .ready(ready1), .read_data(read_data1),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
    .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
  );

  function automatic logic [15:0] hash(input logic [31:0] a);
    return 16'(a * 32'd40503 + 32'd12345);
  endfunction

  // Behavioural SRAM for the main instance; the second one sees read-only contents.
  logic [15:0] sram [0:262143];
  assign sram_dq_in  = sram[sram_addr];
  assign sram_dq_in1 = hash({14'd0, sram_addr1});
  always @(posedge clk) if (!sram_we_n) sram[sram_addr] <= sram_dq_out;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: explicit writes override the power-up pattern.
  logic [31:0] model [int];
  function automatic logic [31:0] model_rd(input logic [16:0] w);
    if (model.exists(int'(w))) return model[int'(w)];
    return {hash({14'd0, w, 1'b1}), hash({14'd0, w, 1'b0})};
  endfunction

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'(BASE);
    return d[18:2];
  endfunction

  logic [31:0] exp_q [$];
  logic [31:0] last_rd = '0;
  logic        cur_wr = 1'b0;
  logic [16:0] cur_word = '0;
  logic [31:0] cur_data = '0;
  logic        mon_off = 1'b1;
  int          low_cnt = 0;

  always @(negedge clk) begin
    if (mon_off) begin
      low_cnt = 0;
    end else begin
      if (!sram_we_n || sram_dq_oe) begin
        check("bus_only_on_write", {31'd0, cur_wr}, 32'd1);
        check("oe_matches_we", {31'd0, sram_dq_oe}, {31'd0, !sram_we_n});
        check("wr_addr_word", {15'd0, sram_addr[17:1]}, {15'd0, cur_word});
        check("wr_dq", {16'd0, sram_dq_out},
              {16'd0, sram_addr[0] ? cur_data[31:16] : cur_data[15:0]});
      end
      if (!ready) begin
        low_cnt++;
      end else if (low_cnt > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          check("ready_low_cycles", 32'(low_cnt), 32'd5);
          check("read_data", read_data, exp_q.pop_front());
        end
        low_cnt = 0;
      end
    end
  end

  // Issue one request in IDLE, scramble inputs while busy, return after DONE.
  task automatic issue(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    logic [16:0] w;
    bit done;
    w = word_of(a);
    if (wr) begin
      model[int'(w)] = d;
    end else begin
      last_rd = model_rd(w);
    end
    exp_q.push_back(last_rd);
    cur_wr = wr; cur_word = w; cur_data = d;
    w_en = wr; r_en = rd; alu_res = a; val_rm = d;
    @(posedge clk); #1;
    w_en = 1'($urandom); r_en = 1'($urandom); alu_res = $urandom; val_rm = $urandom;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1;
    end
    if (!done) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      check("idle_oe", {31'd0, sram_dq_oe}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_w1(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
    int low, we_low;
    bit done;
    low = 0; we_low = 0; done = 0;
    w_en1 = wr; r_en1 = !wr; alu_res1 = a; val_rm1 = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!sram_we_n1) we_low++;
      if (ready1) done = 1; else low++;
    end
    check("w1_ready_low_cycles", 32'(low), 32'd3);
    check("w1_we_low_cycles", 32'(we_low), wr ? 32'd2 : 32'd0);
    check("w1_read_data", read_data1, exp_rd);
    @(posedge clk); #1;
    w_en1 = 1'b0; r_en1 = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d, keep;
    logic [1:0]  kind;
    for (int i = 0; i < 262144; i++) sram[i] = hash(32'(i));
    sram[2] = 16'h5678; sram[3] = 16'h1234;
    model[1] = 32'h1234_5678;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    check("rst_read_data", read_data, 32'd0);
    @(posedge clk); #1;
    mon_off = 1'b0;

    issue(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF);
    check("sram_half0", {16'd0, sram[0]}, 32'h0000_BEEF);
    check("sram_half1", {16'd0, sram[1]}, 32'h0000_DEAD);
    issue(1'b0, 1'b1, 32'd1028, 32'd0);
    idle_cycles(4);

    issue(1'b1, 1'b0, 32'd1032, 32'hCAFE_F00D);
    issue(1'b0, 1'b1, 32'd1032, 32'd0);
    issue(1'b1, 1'b1, 32'd1036, 32'h0BAD_0BAD);
    issue(1'b0, 1'b1, 32'd1037, 32'd0);

    issue(1'b1, 1'b0, 32'd1020, 32'h7777_1111);
    issue(1'b0, 1'b1, 32'd1022, 32'd0);

    for (int n = 0; n < 40; n++) begin
      kind = 2'($urandom_range(0, 2));
      a = (n % 4 == 3) ? $urandom : 32'(BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3));
      d = $urandom;
      issue(kind != 2'd1, kind != 2'd0, a, d);
      if ($urandom_range(0, 2) == 0) @(posedge clk);
      #1;
    end

    // Abort a write during its high half: the word is never read again.
    keep = last_rd;
    check("pre_reset_read_data", read_data, keep);
    mon_off = 1'b1;
    w_en = 1'b1; alu_res = 32'(BASE + 800); val_rm = $urandom;
    @(posedge clk); #1;
    w_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hi_phase_we_n", {31'd0, sram_we_n}, 32'd0);
    check("hi_phase_half", {31'd0, sram_addr[0]}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_read_data", read_data, 32'd0);
    last_rd = '0;
    @(posedge clk); #1;
    mon_off = 1'b0;
    issue(1'b0, 1'b1, 32'd1032, 32'd0);

    run_w1(1'b0, 32'(BASE + 8), 32'd0, {hash(32'd5), hash(32'd4)});
    run_w1(1'b1, 32'(BASE + 12), 32'h1357_9BDF, {hash(32'd5), hash(32'd4)});

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
